// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP decode, 7-bit address match and
// byte-wide strobe interface toward the local logic. SDA is open-drain via SDA_config.
module i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_out,
  output logic       SDA_config,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_request,
  input  logic [7:0] tx_data,
  output logic       busy
);

  // state    | meaning
  // IDLE     | bus free, waiting for START
  // ADDR     | shifting in address + R/W
  // ADDR_ACK | acknowledging our address
  // RX       | receiving a data byte
  // RX_ACK   | acknowledging a received byte
  // TX       | driving a data byte, MSB first
  // TX_ACK   | sampling controller ACK/NACK
  // IGNORE   | not addressed, wait for START/STOP
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl;
  logic                   sda;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic [7:0]             shift;
  logic [7:0]             byte_in;
  logic [3:0]             bit_cnt;
  logic                   rw;
  logic                   first_armed;
  logic                   ack_phase;
  logic                   acked;

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;
  assign byte_in   = {shift[6:0], sda};
  assign SDA_out   = 1'b0;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      // Synchronisers come out of reset at the idle bus level so no edge is invented.
      scl_sync    <= '1;
      sda_sync    <= '1;
      scl_prev    <= 1'b1;
      sda_prev    <= 1'b1;
      state       <= IDLE;
      shift       <= 8'h00;
      bit_cnt     <= 4'd0;
      rw          <= 1'b0;
      first_armed <= 1'b0;
      ack_phase   <= 1'b0;
      acked       <= 1'b0;
      SDA_config  <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;
      tx_request  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
      scl_prev   <= scl;
      sda_prev   <= sda;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      tx_request <= 1'b0;

      if (stop_det) begin
        state      <= IDLE;
        SDA_config <= 1'b0;
        busy       <= 1'b0;
      end else if (start_det) begin
        state      <= ADDR;
        bit_cnt    <= 4'd0;
        SDA_config <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (byte_in[7:1] == ADDRESS && byte_in[7:1] != 7'd0) begin
                state       <= ADDR_ACK;
                busy        <= 1'b1;
                rw          <= byte_in[0];
                first_armed <= 1'b1;
                ack_phase   <= 1'b0;
              end else begin
                state <= IGNORE;
              end
            end
          end
          // First fall pulls SDA for the ACK slot, the second one ends it.
          ADDR_ACK, RX_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              SDA_config <= 1'b1;
              ack_phase  <= 1'b1;
            end else begin
              SDA_config <= 1'b0;
              bit_cnt    <= 4'd0;
              if (state == ADDR_ACK && rw) begin
                tx_request <= 1'b1;
                state      <= TX;
              end else begin
                state <= RX;
              end
            end
          end
          RX: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data     <= byte_in;
              rx_valid    <= 1'b1;
              rx_first    <= first_armed;
              first_armed <= 1'b0;
              ack_phase   <= 1'b0;
              state       <= RX_ACK;
            end
          end
          // tx_data is taken in the cycle tx_request is high, one cycle after the SCL fall.
          TX: if (tx_request) begin
            shift      <= tx_data;
            SDA_config <= ~tx_data[7];
            bit_cnt    <= 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              SDA_config <= 1'b0;
              acked      <= 1'b0;
              state      <= TX_ACK;
            end else begin
              shift      <= {shift[6:0], 1'b0};
              SDA_config <= ~shift[6];
              bit_cnt    <= bit_cnt + 4'd1;
            end
          end
          TX_ACK: if (scl_rise) begin
            if (sda) begin
              state <= IGNORE;
              busy  <= 1'b0;
            end else begin
              acked <= 1'b1;
            end
          end else if (scl_fall && acked) begin
            tx_request <= 1'b1;
            bit_cnt    <= 4'd0;
            state      <= TX;
          end
          IGNORE: SDA_config <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged bus controller plus a scoreboard of expected
// received bytes and a queue of bytes handed out on tx_request.
`timescale 1ns/1ps
module tb_i2c_target;
  localparam int Q = 10;

  logic       cpu_clock = 1'b0;
  logic       reset;
  logic       scl_drv;
  logic       sda_drv;
  logic       glitch;
  logic       sda_line;
  logic       SDA_out, SDA_config, rx_valid, rx_first, tx_request, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data;

  assign sda_line = sda_drv & ~SDA_config;

  i2c_target dut (
    .cpu_clock  (cpu_clock),
    .reset      (reset),
    .SCL_in     (scl_drv),
    .SDA_in     (sda_line),
    .SDA_out    (SDA_out),
    .SDA_config (SDA_config),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_first   (rx_first),
    .tx_request (tx_request),
    .tx_data    (tx_data),
    .busy       (busy)
  );

  always #5 cpu_clock = ~cpu_clock;

  // Observation side: owned by the monitor process only.
  logic [8:0] obs [0:63];
  int         obs_wr = 0;
  int         tx_rd = 0;
  int         tx_req_cnt = 0;
  int         cfg_cnt = 0;
  logic       pop_pending = 1'b0;

  // Stimulus side: owned by the main process only.
  logic [7:0] tx_bytes [0:15];
  int         tx_wr = 0;
  int         obs_rd = 0;
  logic [8:0] exp_q [$];
  int         n_pass = 0;
  int         n_total = 0;

  always @(negedge cpu_clock) begin
    if (pop_pending) tx_rd++;
    pop_pending = tx_request;
    tx_data = (tx_rd < tx_wr) ? tx_bytes[tx_rd] : 8'h00;
    if (tx_request) tx_req_cnt++;
    if (SDA_config) cfg_cnt++;
    if (rx_valid && obs_wr < 64) begin
      obs[obs_wr] = {rx_first, rx_data};
      obs_wr++;
    end
  end

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       match;
  } wvec_t;

  wvec_t wv [5];

  task automatic wait_n(input int n);
    repeat (n) @(negedge cpu_clock);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    if (glitch) begin
      sda_drv = ~b; wait_n(2);
      sda_drv = b;  wait_n(2);
      sda_drv = ~b; wait_n(2);
      sda_drv = b;  wait_n(Q - 6);
    end else begin
      sda_drv = b;  wait_n(Q);
    end
    scl_drv = 1'b1; wait_n(Q);
    s = sda_line;   wait_n(Q);
    scl_drv = 1'b0; wait_n(Q);
  endtask

  task automatic start_cond();
    sda_drv = 1'b1; wait_n(Q);
    scl_drv = 1'b1; wait_n(Q);
    sda_drv = 1'b0; wait_n(Q);
    scl_drv = 1'b0; wait_n(Q);
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0; wait_n(Q);
    scl_drv = 1'b1; wait_n(Q);
    sda_drv = 1'b1; wait_n(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(nack, s);
  endtask

  task automatic drain_rx();
    logic [8:0] e;
    check("rx_count", obs_wr - obs_rd, exp_q.size());
    while (obs_rd < obs_wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rx_data", obs[obs_rd][7:0], e[7:0]);
      check("rx_first", obs[obs_rd][8], e[8]);
      obs_rd++;
    end
    obs_rd = obs_wr;
    exp_q.delete();
  endtask

  task automatic run_write(input wvec_t v);
    logic ack;
    int   cfg0;
    cfg0 = cfg_cnt;
    start_cond();
    write_byte(v.addr, ack);
    check("addr_ack", ack, !v.match);
    check("busy_after_addr", busy, v.match);
    if (v.match) exp_q.push_back({1'b1, v.d0});
    write_byte(v.d0, ack);
    check("d0_ack", ack, !v.match);
    if (v.match) exp_q.push_back({1'b0, v.d1});
    write_byte(v.d1, ack);
    check("d1_ack", ack, !v.match);
    check("busy_before_stop", busy, v.match);
    stop_cond();
    check("busy_after_stop", busy, 0);
    drain_rx();
    if (!v.match) check("sda_never_pulled", cfg_cnt - cfg0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         r0;

    wv[0] = '{addr: 8'h84, d0: 8'h10, d1: 8'hA5, match: 1'b1};
    wv[1] = '{addr: 8'h86, d0: 8'hFF, d1: 8'hFF, match: 1'b0};
    wv[2] = '{addr: 8'h00, d0: 8'h12, d1: 8'h34, match: 1'b0};
    wv[3] = '{addr: 8'h84, d0: 8'h00, d1: 8'hFF, match: 1'b1};
    wv[4] = '{addr: 8'hF0, d0: 8'h55, d1: 8'hAA, match: 1'b0};

    reset = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; glitch = 1'b0;
    wait_n(5);
    check("rst_sda_config", SDA_config, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_request", tx_request, 0);
    check("rst_sda_out", SDA_out, 0);
    reset = 1'b0;
    wait_n(5);

    for (int i = 0; i < 5; i++) run_write(wv[i]);

    // Read two bytes, ACK then NACK.
    tx_bytes[tx_wr] = 8'h3C; tx_wr++;
    tx_bytes[tx_wr] = 8'hC3; tx_wr++;
    r0 = tx_req_cnt;
    start_cond();
    write_byte(8'h85, ack);
    check("rd_addr_ack", ack, 0);
    check("rd_busy", busy, 1);
    read_byte(1'b0, d);
    check("rd_byte0", d, 8'h3C);
    read_byte(1'b1, d);
    check("rd_byte1", d, 8'hC3);
    check("rd_busy_after_nack", busy, 0);
    stop_cond();
    check("rd_tx_requests", tx_req_cnt - r0, 2);

    // Write one byte, repeated START, read one byte.
    tx_bytes[tx_wr] = 8'h77; tx_wr++;
    r0 = tx_req_cnt;
    start_cond();
    write_byte(8'h84, ack);
    check("sr_wr_addr_ack", ack, 0);
    exp_q.push_back({1'b1, 8'h05});
    write_byte(8'h05, ack);
    check("sr_wr_data_ack", ack, 0);
    start_cond();
    check("sr_busy_cleared", busy, 0);
    write_byte(8'h85, ack);
    check("sr_rd_addr_ack", ack, 0);
    read_byte(1'b1, d);
    check("sr_rd_byte", d, 8'h77);
    stop_cond();
    check("sr_tx_requests", tx_req_cnt - r0, 1);
    drain_rx();

    // STOP after four data bits: no byte delivered.
    start_cond();
    write_byte(8'h84, ack);
    check("abort_addr_ack", ack, 0);
    bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
    stop_cond();
    check("abort_busy", busy, 0);
    drain_rx();

    // Reset while the target is driving a 0 bit during a read.
    tx_bytes[tx_wr] = 8'h00; tx_wr++;
    start_cond();
    write_byte(8'h85, ack);
    check("rstx_addr_ack", ack, 0);
    bit_xfer(1'b1, s);
    check("rstx_bit7", s, 0);
    bit_xfer(1'b1, s);
    check("rstx_bit6", s, 0);
    check("rstx_cfg_before", SDA_config, 1);
    reset = 1'b1;
    wait_n(1);
    check("rstx_cfg_after", SDA_config, 0);
    check("rstx_busy_after", busy, 0);
    reset = 1'b0;
    scl_drv = 1'b1; sda_drv = 1'b1;
    wait_n(2 * Q);
    drain_rx();
    run_write('{addr: 8'h84, d0: 8'h5A, d1: 8'h3C, match: 1'b1});

    // SDA chatter while SCL is low must not look like START/STOP.
    glitch = 1'b1;
    run_write('{addr: 8'h84, d0: 8'h96, d1: 8'h69, match: 1'b1});
    glitch = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
